pipelined_subtractor16: RTL



---
 rtl/sub16_pkg.sv | 33 +++
 rtl/pipelined_subtractor16_if.sv | 25 ++
 rtl/ksa8bit.sv | 50 +++++
 rtl/pipelined_subtractor16_sub_stage.sv | 75 +++++++
 rtl/ripple_carry_adder.sv | 32 +++
 rtl/pipelined_subtractor16.sv | 57 +++++
 6 files changed

// File: rtl/sub16_pkg.sv
// Shared widths, segment boundaries and stage payload for the 16-bit pipelined subtractor.
package sub16_pkg;
   localparam int W    = 16;
   localparam int SEG0 = 4;
   localparam int SEG1 = 8;
   localparam int SEG2 = 4;

   localparam int LSB0 = 0;
   localparam int LSB1 = SEG0;
   localparam int LSB2 = SEG0 + SEG1;

   // carry is active-high "no borrow"; cmsb is the carry into the segment's top bit.
   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] nb;
      logic         carry;
      logic         cmsb;
      logic [W-1:0] d;
   } stage_pl_t;

   // Idle payload decodes to D = 0, Bout = 0, V = 0 at the output.
   localparam stage_pl_t PL_IDLE = '{a: '0, nb: '0, carry: 1'b1, cmsb: 1'b1, d: '0};

   function automatic stage_pl_t make_entry(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic bin);
      stage_pl_t pl;
      pl       = PL_IDLE;
      pl.a     = a;
      pl.nb    = ~b;
      pl.carry = ~bin;
      return pl;
   endfunction
endpackage

// File: rtl/pipelined_subtractor16_if.sv
// Operand/result handshake bundle for pipelined_subtractor16.
interface pipelined_subtractor16_if;
   import sub16_pkg::*;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Bin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] D;
   logic         Bout;
   logic         V;

   modport master (
      output in_valid, A, B, Bin, out_ready,
      input  in_ready, out_valid, D, Bout, V
   );

   modport slave (
      input  in_valid, A, B, Bin, out_ready,
      output in_ready, out_valid, D, Bout, V
   );
endinterface

// File: rtl/ksa8bit.sv
// 8-bit Kogge-Stone adder: three prefix levels, carry-in folded in after the prefix tree.
module ksa8bit (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);
   logic [7:0] g0, p0, g1, p1, g2, p2, g3, p3;
   logic [8:0] c;

   assign g0   = a & b;
   assign p0   = a ^ b;
   assign c[0] = cin;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_bit
         if (gi >= 1) begin : g_l1
            assign g1[gi] = g0[gi] | (p0[gi] & g0[gi-1]);
            assign p1[gi] = p0[gi] & p0[gi-1];
         end else begin : g_l1_pass
            assign g1[gi] = g0[gi];
            assign p1[gi] = p0[gi];
         end

         if (gi >= 2) begin : g_l2
            assign g2[gi] = g1[gi] | (p1[gi] & g1[gi-2]);
            assign p2[gi] = p1[gi] & p1[gi-2];
         end else begin : g_l2_pass
            assign g2[gi] = g1[gi];
            assign p2[gi] = p1[gi];
         end

         if (gi >= 4) begin : g_l3
            assign g3[gi] = g2[gi] | (p2[gi] & g2[gi-4]);
            assign p3[gi] = p2[gi] & p2[gi-4];
         end else begin : g_l3_pass
            assign g3[gi] = g2[gi];
            assign p3[gi] = p2[gi];
         end

         // g3/p3 span bits [gi:0], so the carry-in only needs one more AND-OR.
         assign c[gi+1] = g3[gi] | (p3[gi] & cin);
         assign sum[gi] = p0[gi] ^ c[gi];
      end
   endgenerate

   assign cout = c[8];
endmodule

// File: rtl/pipelined_subtractor16_sub_stage.sv
// One pipeline stage: adds its segment of A + ~B + carry and holds the result with a valid bit.
module sub_stage
   import sub16_pkg::*;
#(
   parameter int SEG = 4,
   parameter int LSB = 0
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      up_valid,
   output logic      up_ready,
   input  stage_pl_t up_pl,
   output logic      dn_valid,
   input  logic      dn_ready,
   output stage_pl_t dn_pl
);
   logic             valid_q, valid_d;
   stage_pl_t        pl_q, pl_d;
   logic [SEG-1:0]   seg_sum;
   logic             seg_cout;
   logic             advance;
   logic             load;

   generate
      if (SEG == 8) begin : g_ksa
         ksa8bit u_add (
            .a    (up_pl.a[LSB +: SEG]),
            .b    (up_pl.nb[LSB +: SEG]),
            .cin  (up_pl.carry),
            .sum  (seg_sum),
            .cout (seg_cout)
         );
      end else begin : g_rca
         ripple_carry_adder #(.N(SEG)) u_add (
            .a    (up_pl.a[LSB +: SEG]),
            .b    (up_pl.nb[LSB +: SEG]),
            .cin  (up_pl.carry),
            .sum  (seg_sum),
            .cout (seg_cout)
         );
      end
   endgenerate

   // Loading is allowed whenever the slot is empty or is being drained this cycle.
   assign advance  = valid_q & dn_ready;
   assign up_ready = ~valid_q | advance;
   assign load     = up_valid & up_ready;

   always_comb begin
      valid_d = valid_q;
      pl_d    = pl_q;
      if (load) begin
         valid_d              = 1'b1;
         pl_d                 = up_pl;
         pl_d.d[LSB +: SEG]   = seg_sum;
         pl_d.carry           = seg_cout;
         pl_d.cmsb            = up_pl.a[LSB+SEG-1] ^ up_pl.nb[LSB+SEG-1] ^ seg_sum[SEG-1];
      end else if (advance) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         pl_q    <= PL_IDLE;
      end else begin
         valid_q <= valid_d;
         pl_q    <= pl_d;
      end
   end

   assign dn_valid = valid_q;
   assign dn_pl    = pl_q;
endmodule

// File: rtl/ripple_carry_adder.sv
// Parameterised ripple-carry adder used for the 4-bit end segments.
module ripple_carry_adder #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);
   logic [N-1:0] p;
   logic [N-1:0] g;
   logic         c;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_pg
         assign p[gi] = a[gi] ^ b[gi];
         assign g[gi] = a[gi] & b[gi];
      end
   endgenerate

   always_comb begin
      c   = cin;
      sum = '0;
      for (int i = 0; i < N; i++) begin
         sum[i] = p[i] ^ c;
         c      = g[i] | (p[i] & c);
      end
      cout = c;
   end
endmodule

// File: rtl/pipelined_subtractor16.sv
// Three-stage 16-bit subtractor (4/8/4 segments) computing A - B - Bin with Bout and V.
module pipelined_subtractor16
   import sub16_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   pipelined_subtractor16_if.slave  bus
);
   stage_pl_t entry_pl, s1_pl, s2_pl, s3_pl;
   logic      s1_valid, s2_valid, s3_valid;
   logic      s1_ready, s2_ready, s3_ready;
   logic      unused_pl;

   assign entry_pl = make_entry(bus.A, bus.B, bus.Bin);

   sub_stage #(.SEG(SEG0), .LSB(LSB0)) u_stage1 (
      .clk      (clk),
      .rst      (rst),
      .up_valid (bus.in_valid),
      .up_ready (s1_ready),
      .up_pl    (entry_pl),
      .dn_valid (s1_valid),
      .dn_ready (s2_ready),
      .dn_pl    (s1_pl)
   );

   sub_stage #(.SEG(SEG1), .LSB(LSB1)) u_stage2 (
      .clk      (clk),
      .rst      (rst),
      .up_valid (s1_valid),
      .up_ready (s2_ready),
      .up_pl    (s1_pl),
      .dn_valid (s2_valid),
      .dn_ready (s3_ready),
      .dn_pl    (s2_pl)
   );

   sub_stage #(.SEG(SEG2), .LSB(LSB2)) u_stage3 (
      .clk      (clk),
      .rst      (rst),
      .up_valid (s2_valid),
      .up_ready (s3_ready),
      .up_pl    (s2_pl),
      .dn_valid (s3_valid),
      .dn_ready (bus.out_ready),
      .dn_pl    (s3_pl)
   );

   assign bus.in_ready  = s1_ready & ~rst;
   assign bus.out_valid = s3_valid;
   assign bus.D         = s3_pl.d;
   // Final-stage cmsb is the carry into bit 15.
   assign bus.Bout      = ~s3_pl.carry;
   assign bus.V         = s3_pl.carry ^ s3_pl.cmsb;

   assign unused_pl     = ^{s3_pl.a, s3_pl.nb};
endmodule
